control_unit: RTL and testbench

- Registered opcode decoder for the 8-bit CPU; sits between the instruction register and the ALU/register-file write port.
- Accepts a 4-bit opcode qualified by a valid strobe; one cycle later presents the ALU operation select, register-file write enable, and an illegal-opcode indication.
- Also keeps a sticky illegal-opcode flag and a saturating illegal-opcode counter for debug.

---
 rtl/control_unit.sv | 107 ++++++++++
 tb/tb_control_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : registered 4-bit opcode decoder with illegal-opcode debug
//                flag and saturating counter.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [3:0]       Opcode,
  input  logic             clr_illegal,
  output logic [2:0]       ALUOp,
  output logic             RegWrite,
  output logic             ctrl_valid,
  output logic             illegal_op,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [2:0]       w_aluop;
  logic             w_regwrite;
  logic             w_illegal;
  logic             w_inc;

  logic [2:0]       r_aluop;
  logic             r_regwrite;
  logic             r_valid;
  logic             r_illegal;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_aluop    = 3'b000;
    w_regwrite = 1'b1;
    w_illegal  = 1'b0;
    case (Opcode)
      4'b0000: w_regwrite = 1'b0;
      4'b0001: w_aluop    = 3'b000;
      4'b0010: w_aluop    = 3'b001;
      4'b0011: w_aluop    = 3'b010;
      4'b0100: w_aluop    = 3'b011;
      4'b0101: w_aluop    = 3'b100;
      4'b0110: w_aluop    = 3'b101;
      4'b0111: w_aluop    = 3'b110;
      4'b1000: w_aluop    = 3'b111;
      default: begin
        w_regwrite = 1'b0;
        w_illegal  = 1'b1;
      end
    endcase
  end

  assign w_inc = instr_valid & w_illegal;

  // ALUOp is deliberately left holding when no opcode is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluop    <= 3'b000;
      r_regwrite <= 1'b0;
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (instr_valid) begin
      r_aluop    <= w_aluop;
      r_regwrite <= w_regwrite;
      r_valid    <= 1'b1;
      r_illegal  <= w_illegal;
    end else begin
      r_regwrite <= 1'b0;
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
    end
  end

  // A new illegal opcode takes priority over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_inc) begin
      r_sticky <= 1'b1;
      if (clr_illegal)
        r_cnt <= c_cnt_one;
      else if (r_cnt != c_cnt_max)
        r_cnt <= r_cnt + c_cnt_one;
    end else if (clr_illegal) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end
  end

  assign ALUOp          = r_aluop;
  assign RegWrite       = r_regwrite;
  assign ctrl_valid     = r_valid;
  assign illegal_op     = r_illegal;
  assign illegal_sticky = r_sticky;
  assign illegal_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit : vector table plus hand sequences for control_unit, with a
//                   second instance at CNT_W=2 for counter saturation.
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] Opcode;
  logic       clr_illegal;

  logic [2:0] alu_a, alu_b;
  logic       rw_a, rw_b, cv_a, cv_b, ill_a, ill_b, stk_a, stk_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  control_unit #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .Opcode(Opcode),
    .clr_illegal(clr_illegal), .ALUOp(alu_a), .RegWrite(rw_a),
    .ctrl_valid(cv_a), .illegal_op(ill_a), .illegal_sticky(stk_a),
    .illegal_cnt(cnt_a)
  );

  control_unit #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .Opcode(Opcode),
    .clr_illegal(clr_illegal), .ALUOp(alu_b), .RegWrite(rw_b),
    .ctrl_valid(cv_b), .illegal_op(ill_b), .illegal_sticky(stk_b),
    .illegal_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [2:0] alu;
    logic       rw;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [2:0] alu;
    logic       rw;
    logic       cv;
    logic       ill;
    logic       stk;
    int         cnt;
    int         cnt2;
  } exp_t;

  vec_t vecs [16];
  exp_t sb [$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] m_alu;
  logic       m_stk;
  int         m_cnt, m_cnt2;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("ALUOp", alu_a, e.alu);
    chk("RegWrite", rw_a, e.rw);
    chk("ctrl_valid", cv_a, e.cv);
    chk("illegal_op", ill_a, e.ill);
    chk("illegal_sticky", stk_a, e.stk);
    chk("illegal_cnt", cnt_a, e.cnt);
    chk("sat_ALUOp", alu_b, e.alu);
    chk("sat_RegWrite", rw_b, e.rw);
    chk("sat_ctrl_valid", cv_b, e.cv);
    chk("sat_illegal_op", ill_b, e.ill);
    chk("sat_illegal_sticky", stk_b, e.stk);
    chk("sat_illegal_cnt", cnt_b, e.cnt2);
  endtask

  // Drive one cycle of stimulus, predict the registered result, check it.
  task automatic step(input logic v, input logic [3:0] op, input logic clr,
                      input logic [2:0] e_alu, input logic e_rw, input logic e_ill);
    exp_t e;
    logic inc;
    @(negedge clk);
    instr_valid = v;
    Opcode      = op;
    clr_illegal = clr;
    inc   = v & e_ill;
    e.cv  = v;
    e.rw  = v & e_rw;
    e.ill = inc;
    if (v) m_alu = e_alu;
    e.alu = m_alu;
    if (inc) begin
      m_stk  = 1'b1;
      m_cnt  = clr ? 1 : ((m_cnt  < 255) ? m_cnt  + 1 : 255);
      m_cnt2 = clr ? 1 : ((m_cnt2 < 3)   ? m_cnt2 + 1 : 3);
    end else if (clr) begin
      m_stk  = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
    end
    e.stk  = m_stk;
    e.cnt  = m_cnt;
    e.cnt2 = m_cnt2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ALUOp"}, alu_a, 0);
    chk({tag, "_RegWrite"}, rw_a, 0);
    chk({tag, "_ctrl_valid"}, cv_a, 0);
    chk({tag, "_illegal_op"}, ill_a, 0);
    chk({tag, "_sticky"}, stk_a, 0);
    chk({tag, "_cnt"}, cnt_a, 0);
    chk({tag, "_sat_cnt"}, cnt_b, 0);
    chk({tag, "_sat_sticky"}, stk_b, 0);
  endtask

  task automatic model_reset();
    m_alu  = 3'b000;
    m_stk  = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  initial begin
    vecs[0]  = '{4'h0, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{4'h1, 3'b000, 1'b1, 1'b0};
    vecs[2]  = '{4'h2, 3'b001, 1'b1, 1'b0};
    vecs[3]  = '{4'h3, 3'b010, 1'b1, 1'b0};
    vecs[4]  = '{4'h4, 3'b011, 1'b1, 1'b0};
    vecs[5]  = '{4'h5, 3'b100, 1'b1, 1'b0};
    vecs[6]  = '{4'h6, 3'b101, 1'b1, 1'b0};
    vecs[7]  = '{4'h7, 3'b110, 1'b1, 1'b0};
    vecs[8]  = '{4'h8, 3'b111, 1'b1, 1'b0};
    for (int i = 9; i < 16; i++) vecs[i] = '{4'(i), 3'b000, 1'b0, 1'b1};

    rst_n = 1'b0; instr_valid = 1'b0; Opcode = 4'h0; clr_illegal = 1'b0;
    model_reset();
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep all opcodes back to back; 7 illegal ones saturate the 2-bit counter
    for (int i = 0; i < 16; i++)
      step(1'b1, vecs[i].op, 1'b0, vecs[i].alu, vecs[i].rw, vecs[i].ill);

    // Clear only, then SHR followed by an idle cycle to observe ALUOp holding
    step(1'b0, 4'h0, 1'b1, 3'b000, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b0, 3'b111, 1'b1, 1'b0);
    step(1'b0, 4'h3, 1'b0, 3'b000, 1'b0, 1'b0);

    // Gaps: ADD, idle, idle, XOR
    step(1'b1, 4'h1, 1'b0, 3'b000, 1'b1, 1'b0);
    step(1'b0, 4'h5, 1'b0, 3'b000, 1'b0, 1'b0);
    step(1'b0, 4'h5, 1'b0, 3'b000, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 3'b100, 1'b1, 1'b0);

    // Illegal opcodes interleaved with legal ones, then more to saturate
    step(1'b1, 4'h1, 1'b0, 3'b000, 1'b1, 1'b0);
    step(1'b1, 4'h9, 1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b1, 4'h2, 1'b0, 3'b001, 1'b1, 1'b0);
    step(1'b1, 4'hC, 1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b1, 4'h4, 1'b0, 3'b011, 1'b1, 1'b0);
    step(1'b1, 4'hF, 1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b1, 4'hB, 1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b1, 4'hD, 1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b1, 3'b000, 1'b0, 1'b0);

    // Clear on the same edge as an illegal opcode, then with a legal one
    step(1'b1, 4'hA, 1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b1, 4'hA, 1'b1, 3'b000, 1'b0, 1'b1);
    step(1'b1, 4'h1, 1'b1, 3'b000, 1'b1, 1'b0);
    step(1'b1, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);

    // Mid-cycle reset while ctrl_valid=1, no clock edge involved
    step(1'b1, 4'hE, 1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b1, 4'h6, 1'b0, 3'b101, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    clr_illegal = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'h5, 1'b0, 3'b100, 1'b1, 1'b0);
    step(1'b1, 4'h7, 1'b0, 3'b110, 1'b1, 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
